// File: rtl/vga_timing_if.sv
// Video bus carried between pipeline stages: pixel position, sync/blank strobes and colour.
interface vga_if;
  logic [10:0] hcount;
  logic [10:0] vcount;
  logic        hsync;
  logic        vsync;
  logic        hblnk;
  logic        vblnk;
  logic [11:0] rgb;

  modport out (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
  modport in  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
endinterface

// File: rtl/vga_timing.sv
// 800x600@60 Hz VGA timing generator: free-running counters plus registered sync/blank strobes.
// Optional simulation-only range checks are enabled by defining VGA_TIMING_CHECK_EN.
package vga_pkg;
  parameter logic [10:0] HOR_BLANK_START = 11'd800;
  parameter logic [10:0] HOR_SYNC_START  = 11'd840;
  parameter logic [10:0] HOR_SYNC_END    = 11'd967;
  parameter logic [10:0] HOR_BLANK_END   = 11'd1055;
  parameter logic [10:0] HOR_TOTAL_TIME  = 11'd1056;
  parameter logic [10:0] VER_BLANK_START = 11'd600;
  parameter logic [10:0] VER_SYNC_START  = 11'd601;
  parameter logic [10:0] VER_SYNC_END    = 11'd604;
  parameter logic [10:0] VER_BLANK_END   = 11'd627;
  parameter logic [10:0] VER_TOTAL_TIME  = 11'd628;
endpackage

module vga_timing
  import vga_pkg::*;
(
  input  logic clk,
  input  logic rst,
  vga_if.out   out
);

  logic [10:0] hcount_q, hcount_d;
  logic [10:0] vcount_q, vcount_d;
  logic        hsync_q, hsync_d;
  logic        vsync_q, vsync_d;
  logic        hblnk_q, hblnk_d;
  logic        vblnk_q, vblnk_d;

  // NOTE: every variable gets a default at the top of always_comb, so no path can infer a latch.
  always_comb begin
    hcount_d = hcount_q + 11'd1;
    vcount_d = vcount_q;
    // >= rather than == so a corrupted count still returns to the legal range.
    if (hcount_q >= HOR_TOTAL_TIME - 11'd1) begin
      hcount_d = 11'd0;
      if (vcount_q >= VER_TOTAL_TIME - 11'd1) begin
        vcount_d = 11'd0;
      end else begin
        vcount_d = vcount_q + 11'd1;
      end
    end

    // Strobes decode the next counts so both land on the same edge.
    hblnk_d = (hcount_d >= HOR_BLANK_START) && (hcount_d <= HOR_BLANK_END);
    hsync_d = (hcount_d >= HOR_SYNC_START)  && (hcount_d <= HOR_SYNC_END);
    vblnk_d = (vcount_d >= VER_BLANK_START) && (vcount_d <= VER_BLANK_END);
    vsync_d = (vcount_d >= VER_SYNC_START)  && (vcount_d <= VER_SYNC_END);
  end

  // NOTE: sequential state is updated with non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst) begin
      hcount_q <= 11'd0;
      vcount_q <= 11'd0;
      hsync_q  <= 1'b0;
      vsync_q  <= 1'b0;
      hblnk_q  <= 1'b0;
      vblnk_q  <= 1'b0;
    end else begin
      hcount_q <= hcount_d;
      vcount_q <= vcount_d;
      hsync_q  <= hsync_d;
      vsync_q  <= vsync_d;
      hblnk_q  <= hblnk_d;
      vblnk_q  <= vblnk_d;
    end
  end

  assign out.hcount = hcount_q;
  assign out.vcount = vcount_q;
  assign out.hsync  = hsync_q;
  assign out.vsync  = vsync_q;
  assign out.hblnk  = hblnk_q;
  assign out.vblnk  = vblnk_q;
  assign out.rgb    = 12'h000;

`ifdef VGA_TIMING_CHECK_EN
  always @(posedge clk) begin
    if (!rst) begin
      assert (hcount_q <= HOR_BLANK_END) else $error("hcount out of range");
      assert (vcount_q <= VER_BLANK_END) else $error("vcount out of range");
      assert (hblnk_q == ((hcount_q >= HOR_BLANK_START) && (hcount_q <= HOR_BLANK_END)))
        else $error("hblnk disagrees with hcount");
      assert (hsync_q == ((hcount_q >= HOR_SYNC_START) && (hcount_q <= HOR_SYNC_END)))
        else $error("hsync disagrees with hcount");
      assert (vblnk_q == ((vcount_q >= VER_BLANK_START) && (vcount_q <= VER_BLANK_END)))
        else $error("vblnk disagrees with vcount");
      assert (vsync_q == ((vcount_q >= VER_SYNC_START) && (vcount_q <= VER_SYNC_END)))
        else $error("vsync disagrees with vcount");
    end
  end
`else
  // Range checks compiled out; the generated logic is unchanged.
`endif

endmodule

// File: tb/tb_vga_timing.sv
// Bench for vga_timing: a frame-position model checked every cycle, hand-computed boundary points,
// and random jumps of the counters to reach lines a short run could not otherwise visit.
module tb_vga_timing;

  localparam int LINE  = 1056;
  localparam int LINES = 628;
  localparam int FRAME = LINE * LINES;

  logic clk;
  logic rst;
  vga_if vga_bus ();

  vga_timing dut (
    .clk (clk),
    .rst (rst),
    .out (vga_bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string name, input logic [37:0] act, input logic [37:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got h=%0d v=%0d hs/vs/hb/vb=%b%b%b%b rgb=%h, expected h=%0d v=%0d hs/vs/hb/vb=%b%b%b%b rgb=%h",
               name, act[37:27], act[26:16], act[15], act[14], act[13], act[12], act[11:0],
               exp[37:27], exp[26:16], exp[15], exp[14], exp[13], exp[12], exp[11:0]);
    end
  endtask

  function automatic logic [37:0] dut_vec();
    return {vga_bus.hcount, vga_bus.vcount, vga_bus.hsync, vga_bus.vsync,
            vga_bus.hblnk, vga_bus.vblnk, vga_bus.rgb};
  endfunction

  // Model: the frame is one linear sequence of FRAME positions; outputs are range predicates of it.
  function automatic logic [37:0] expect_at(input int p);
    int  h, v;
    logic hs, vs, hb, vb;
    h  = p % LINE;
    v  = p / LINE;
    hb = (h >= 800);
    hs = (h >= 840) && (h <= 967);
    vb = (v >= 600);
    vs = (v >= 601) && (v <= 604);
    return {11'(h), 11'(v), hs, vs, hb, vb, 12'h000};
  endfunction

  // Counter jumps requested by the stimulus; the compare process picks them up on the next edge.
  logic [10:0] dep_h, dep_v;
  int dep_seq  = 0;
  int dep_seen = 0;
  int dep_p    = 0;

  int model_p;
  bit started = 1'b0;

  always begin
    @(posedge clk);
    if (rst) begin
      model_p = 0;
      started = 1'b1;
    end else if (dep_seq != dep_seen) begin
      model_p  = (dep_p + 1) % FRAME;
      dep_seen = dep_seq;
    end else begin
      model_p = (model_p + 1) % FRAME;
    end
    #1;
    if (started) check($sformatf("frame_pos_%0d", model_p), dut_vec(), expect_at(model_p));
  end

  task automatic advance(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic jump_to(input int h, input int v);
    @(negedge clk);
    dep_h = 11'(h);
    dep_v = 11'(v);
    force dut.hcount_q = dep_h;
    force dut.vcount_q = dep_v;
    release dut.hcount_q;
    release dut.vcount_q;
    dep_p = v * LINE + h;
    dep_seq++;
  endtask

  task automatic chk_pt(input string name, input int h, input int v,
                        input logic hs, input logic vs, input logic hb, input logic vb);
    check(name, dut_vec(), {11'(h), 11'(v), hs, vs, hb, vb, 12'h000});
  endtask

  initial begin
    #(10 * 200000);
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int vs_cycles;
    int pick;
    int marks [8];
    marks = '{799, 839, 967, 1055, 599*LINE + 1050, 600*LINE + 1050,
              604*LINE + 1050, 627*LINE + 1000};

    rst = 1'b1;
    advance(3);
    chk_pt("reset_state", 0, 0, 0, 0, 0, 0);

    @(negedge clk);
    rst = 1'b0;
    advance(1);
    chk_pt("first_edge", 1, 0, 0, 0, 0, 0);

    // Line 0 horizontal boundaries.
    advance(798);  chk_pt("h799",  799, 0, 0, 0, 0, 0);
    advance(1);    chk_pt("h800",  800, 0, 0, 0, 1, 0);
    advance(39);   chk_pt("h839",  839, 0, 0, 0, 1, 0);
    advance(1);    chk_pt("h840",  840, 0, 1, 0, 1, 0);
    advance(127);  chk_pt("h967",  967, 0, 1, 0, 1, 0);
    advance(1);    chk_pt("h968",  968, 0, 0, 0, 1, 0);
    advance(87);   chk_pt("h1055", 1055, 0, 0, 0, 1, 0);
    advance(1);    chk_pt("line_wrap", 0, 1, 0, 0, 0, 0);

    // Vertical blanking and sync.
    jump_to(1050, 599);
    advance(5);    chk_pt("v599_end", 1055, 599, 0, 0, 1, 0);
    advance(1);    chk_pt("v600_start", 0, 600, 0, 0, 0, 1);
    advance(1055); chk_pt("v600_end", 1055, 600, 0, 0, 1, 1);
    advance(1);    chk_pt("vsync_rise", 0, 601, 0, 1, 0, 1);
    vs_cycles = 0;
    for (int i = 0; i < 5000; i++) begin
      if (vga_bus.vsync !== 1'b1) break;
      vs_cycles++;
      advance(1);
    end
    check("vsync_width", 38'(vs_cycles), 38'(4 * LINE));
    chk_pt("vsync_fall", 0, 605, 0, 0, 0, 1);

    // Frame wrap.
    jump_to(1050, 627);
    advance(5);    chk_pt("frame_end", 1055, 627, 0, 0, 1, 1);
    advance(1);    chk_pt("frame_wrap", 0, 0, 0, 0, 0, 0);

    // Reset in the middle of a frame.
    jump_to(495, 300);
    advance(5);    chk_pt("mid_frame", 500, 300, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b1;
    advance(1);    chk_pt("mid_reset", 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    advance(1);    chk_pt("after_reset", 1, 0, 0, 0, 0, 0);

    // Random jumps, some near boundaries, with occasional reset pulses.
    for (int it = 0; it < 60; it++) begin
      if ($urandom_range(0, 1) == 0) begin
        pick = marks[$urandom_range(0, 7)] - int'($urandom_range(0, 20));
      end else begin
        pick = int'($urandom_range(0, FRAME - 1));
      end
      jump_to(pick % LINE, pick / LINE);
      advance(int'($urandom_range(1, 300)));
      if ($urandom_range(0, 7) == 0) begin
        @(negedge clk);
        rst = 1'b1;
        advance(int'($urandom_range(1, 3)));
        @(negedge clk);
        rst = 1'b0;
        advance(int'($urandom_range(1, 50)));
      end
    end

    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
